// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage_if
// Brief    : Data-memory request/response bus between the memory stage and
//            the data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_stage_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Brief    : Pipeline memory stage: issues data-memory accesses for loads and
//            stores, formats load data and selects the writeback value.
// Revision : 1.0 - initial release
// ============================================================================
module memory_stage (
    input  wire         clk,
    input  wire         rst_n,
    input  wire  [31:0] PC_x,
    input  wire  [31:0] inst_x,
    input  wire  [31:0] ALU_out,
    input  wire  [31:0] write_data,
    input  wire         valid_x,
    output logic        stall_m,
    memory_stage_if.master bus,
    output logic        valid_m,
    output logic [31:0] PC_m,
    output logic [31:0] inst_m,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_m,
    output logic        RegWE_m,
    output logic        misalign_m
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_alu;
    logic [31:0] r_wdata;
    logic        r_valid;
    logic [31:0] r_ld_data;

    // Only meaningful for load/store opcodes; callers gate with the mem decode.
    function automatic logic f_misaligned(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic l_half;
        logic l_byte;
        l_half = ((op == c_OP_LOAD)  && (f3[1:0] == 2'b01)) ||
                 ((op == c_OP_STORE) && (f3 == 3'b001));
        l_byte = ((op == c_OP_LOAD)  && (f3[1:0] == 2'b00)) ||
                 ((op == c_OP_STORE) && (f3 == 3'b000));
        f_misaligned = l_half ? off[0] : (!l_byte && (off != 2'b00));
    endfunction

    logic       w_x_mem;
    logic       w_x_mis;
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [1:0] w_off;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_mem;
    logic       w_mis;

    assign w_x_mem    = (inst_x[6:0] == c_OP_LOAD) || (inst_x[6:0] == c_OP_STORE);
    assign w_x_mis    = f_misaligned(inst_x[6:0], inst_x[14:12], ALU_out[1:0]);
    assign w_op       = r_inst[6:0];
    assign w_f3       = r_inst[14:12];
    assign w_off      = r_alu[1:0];
    assign w_is_load  = (w_op == c_OP_LOAD);
    assign w_is_store = (w_op == c_OP_STORE);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_mis      = w_is_mem && f_misaligned(w_op, w_f3, w_off);

    // The next state is decided from the execute slot on every capture edge.
    always_comb begin
        w_state_nxt        = r_state;
        stall_m            = 1'b0;
        valid_m            = 1'b0;
        bus.dmem_req_valid = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                valid_m     = (r_state == S_DONE) ? 1'b1 : r_valid;
                w_state_nxt = (valid_x && w_x_mem && !w_x_mis) ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                stall_m            = 1'b1;
                bus.dmem_req_valid = 1'b1;
                if (bus.dmem_req_ready) begin
                    w_state_nxt = w_is_store ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall_m = 1'b1;
                if (bus.dmem_rsp_valid) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_fmt;

    always_comb begin
        w_ld_byte = bus.dmem_rdata[7:0];
        case (w_off)
            2'd0:    w_ld_byte = bus.dmem_rdata[7:0];
            2'd1:    w_ld_byte = bus.dmem_rdata[15:8];
            2'd2:    w_ld_byte = bus.dmem_rdata[23:16];
            default: w_ld_byte = bus.dmem_rdata[31:24];
        endcase
        w_ld_half = w_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (w_f3)
            3'b000:  w_ld_fmt = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_fmt = {24'd0, w_ld_byte};
            3'b001:  w_ld_fmt = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_fmt = {16'd0, w_ld_half};
            default: w_ld_fmt = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= 32'd0;
            r_inst    <= 32'd0;
            r_alu     <= 32'd0;
            r_wdata   <= 32'd0;
            r_valid   <= 1'b0;
            r_ld_data <= 32'd0;
        end else begin
            if (!stall_m) begin
                r_pc    <= PC_x;
                r_inst  <= inst_x;
                r_alu   <= ALU_out;
                r_wdata <= write_data;
                r_valid <= valid_x;
            end
            if ((r_state == S_WAIT) && bus.dmem_rsp_valid) begin
                r_ld_data <= w_ld_fmt;
            end
        end
    end

    logic [3:0]  w_strb;
    logic [31:0] w_st_data;

    always_comb begin
        case (w_f3)
            3'b000: begin
                w_strb    = 4'b0001 << w_off;
                w_st_data = {4{r_wdata[7:0]}};
            end
            3'b001: begin
                w_strb    = 4'b0011 << w_off;
                w_st_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_strb    = 4'b1111;
                w_st_data = r_wdata;
            end
        endcase
    end

    // Request fields derive only from the stage register, so they hold steady while stalled.
    assign bus.dmem_addr  = {r_alu[31:2], 2'b00};
    assign bus.dmem_we    = (r_state == S_REQ) && w_is_store;
    assign bus.dmem_wstrb = bus.dmem_we ? w_strb : 4'b0000;
    assign bus.dmem_wdata = w_st_data;

    assign PC_m       = r_pc;
    assign inst_m     = r_inst;
    assign rd_m       = r_inst[11:7];
    assign misalign_m = r_valid && w_mis;

    always_comb begin
        if (w_is_load) begin
            wb_data = r_ld_data;
        end else if ((w_op == c_OP_JAL) || (w_op == c_OP_JALR)) begin
            wb_data = r_pc + 32'd4;
        end else begin
            wb_data = r_alu;
        end
    end

    assign RegWE_m = valid_m && !w_is_store && (w_op != c_OP_BRANCH) &&
                     (rd_m != 5'd0) && !misalign_m;

endmodule
`default_nettype wire
